mul_share_ctrl: RTL and testbench



---
 rtl/mul_share_ctrl_if.sv | 48 ++++
 rtl/mul_share_ctrl.sv | 121 ++++++++++++
 tb/tb_mul_share_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_share_ctrl_if.sv
// Request/response handshake bundle between two clients and the shared-multiplier controller.
interface mul_share_ctrl_if #(
    parameter int TAG_W = 4
);
    logic                    req0_valid;
    logic                    req0_ready;
    logic signed [15:0]      req0_a;
    logic signed [15:0]      req0_b;
    logic [TAG_W-1:0]        req0_tag;

    logic                    req1_valid;
    logic                    req1_ready;
    logic signed [15:0]      req1_a;
    logic signed [15:0]      req1_b;
    logic [TAG_W-1:0]        req1_tag;

    logic                    resp0_valid;
    logic                    resp0_ready;
    logic signed [31:0]      resp0_product;
    logic [TAG_W-1:0]        resp0_tag;

    logic                    resp1_valid;
    logic                    resp1_ready;
    logic signed [31:0]      resp1_product;
    logic [TAG_W-1:0]        resp1_tag;

    modport master (
        output req0_valid, req0_a, req0_b, req0_tag,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_tag,
        input  req1_ready,
        input  resp0_valid, resp0_product, resp0_tag,
        output resp0_ready,
        input  resp1_valid, resp1_product, resp1_tag,
        output resp1_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_tag,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_tag,
        output req1_ready,
        output resp0_valid, resp0_product, resp0_tag,
        input  resp0_ready,
        output resp1_valid, resp1_product, resp1_tag,
        input  resp1_ready
    );
endinterface

// File: rtl/mul_share_ctrl.sv
// Shares one combinational 16x16 signed multiplier between two requesters; operands are
// held for CALC_CYCLES cycles (multicycle path) before the product is captured and returned.
module multiplier (
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic signed [31:0] answer
);
    assign answer = 32'(a) * 32'(b);
endmodule

module mul_share_ctrl #(
    parameter int CALC_CYCLES = 2,
    parameter int TAG_W       = 4
) (
    input  logic            clk,
    input  logic            rst,
    mul_share_ctrl_if.slave bus,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(CALC_CYCLES - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               last_grant_q, last_grant_d;
    logic               owner_q, owner_d;
    logic signed [15:0] op_a_q, op_a_d;
    logic signed [15:0] op_b_q, op_b_d;
    logic signed [31:0] prod_q, prod_d;
    logic [TAG_W-1:0]   tag_q, tag_d;

    logic signed [31:0] mul_answer;
    logic               grant0, grant1;
    logic               req0_ready_c, req1_ready_c;

    // Operand registers feed the multiplier directly and stay frozen through CALC.
    multiplier u_mul (
        .a      (op_a_q),
        .b      (op_b_q),
        .answer (mul_answer)
    );

    always_comb begin
        grant0       = bus.req0_valid & (~bus.req1_valid | last_grant_q);
        grant1       = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
        req0_ready_c = 1'b0;
        req1_ready_c = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        prod_d       = prod_q;
        tag_d        = tag_q;

        case (state_q)
            IDLE: begin
                req0_ready_c = grant0 & ~rst;
                req1_ready_c = grant1 & ~rst;
                if (grant0 | grant1) begin
                    owner_d      = grant1;
                    last_grant_d = grant1;
                    op_a_d       = grant1 ? bus.req1_a   : bus.req0_a;
                    op_b_d       = grant1 ? bus.req1_b   : bus.req0_b;
                    tag_d        = grant1 ? bus.req1_tag : bus.req0_tag;
                    cnt_d        = CNT_LOAD;
                    state_d      = CALC;
                end
            end
            CALC: begin
                if (cnt_q == 4'd0) begin
                    prod_d  = mul_answer;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // Only the owner's ready completes the handshake.
                if (owner_q ? bus.resp1_ready : bus.resp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            prod_q       <= '0;
            tag_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            prod_q       <= prod_d;
            tag_q        <= tag_d;
        end
    end

    assign bus.req0_ready    = req0_ready_c;
    assign bus.req1_ready    = req1_ready_c;
    assign bus.resp0_valid   = (state_q == RESP) & ~owner_q;
    assign bus.resp1_valid   = (state_q == RESP) &  owner_q;
    assign bus.resp0_product = prod_q;
    assign bus.resp1_product = prod_q;
    assign bus.resp0_tag     = tag_q;
    assign bus.resp1_tag     = tag_q;
    assign busy              = (state_q != IDLE);
endmodule

// File: tb/tb_mul_share_ctrl.sv
// Scoreboard bench for mul_share_ctrl: a CALC_CYCLES=2 instance under directed and random
// traffic, plus a CALC_CYCLES=1 instance checked for latency and back-to-back throughput.
module tb_mul_share_ctrl;
    localparam int TW    = 4;
    localparam int CALC0 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy0, busy1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_share_ctrl_if #(.TAG_W(TW)) bus0 ();
    mul_share_ctrl_if #(.TAG_W(TW)) bus1 ();

    mul_share_ctrl #(.CALC_CYCLES(CALC0), .TAG_W(TW)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave), .busy(busy0));
    mul_share_ctrl #(.CALC_CYCLES(1), .TAG_W(TW)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave), .busy(busy1));

    typedef struct {
        int port;
        int prod;
        int tag;
        int due;
    } exp_t;

    exp_t sbq[$];
    exp_t cur[2];
    bit   active[2];
    int   outstanding = 0;
    int   last_w      = 1;
    int   rr_mode     = 0;
    logic man0 = 1'b1, man1 = 1'b1;

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic fail(input string nm, input string act, input string req);
        total++;
        bad++;
        $display("FAIL %s: got %s, expected %s (cycle %0d)", nm, act, req, cyc);
    endtask

    // Response-ready driver: always ready, random, or manual.
    always @(posedge clk) begin
        #1;
        if (rr_mode == 0) begin
            bus0.resp0_ready = 1'b1;
            bus0.resp1_ready = 1'b1;
        end else if (rr_mode == 1) begin
            bus0.resp0_ready = ($urandom_range(0, 2) != 0);
            bus0.resp1_ready = ($urandom_range(0, 2) != 0);
        end else begin
            bus0.resp0_ready = man0;
            bus0.resp1_ready = man1;
        end
    end

    // Monitor: sampled at negedge, where inputs and combinational readies are settled
    // for the coming rising edge.
    logic m_v0, m_v1, m_r0, m_r1, m_rv, m_rr;
    logic signed [31:0] m_rp;
    logic [TW-1:0] m_rt;
    int   m_w;
    exp_t m_e;

    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            outstanding = 0;
            active[0]   = 1'b0;
            active[1]   = 1'b0;
            last_w      = 1;
        end else begin
            m_v0 = bus0.req0_valid;
            m_v1 = bus0.req1_valid;
            m_r0 = bus0.req0_ready;
            m_r1 = bus0.req1_ready;
            chk("ready_onehot", m_r0 & m_r1, 0);
            chk("ready_expect", m_r0 | m_r1, (outstanding == 0) && (m_v0 || m_v1));
            chk("busy", busy0, outstanding != 0);
            if ((m_v0 && m_r0) || (m_v1 && m_r1)) begin
                m_w = (m_v1 && m_r1) ? 1 : 0;
                if (m_v0 && m_v1) chk("arb_winner", m_w, 1 - last_w);
                last_w   = m_w;
                m_e.port = m_w;
                m_e.prod = (m_w == 1) ? int'(bus0.req1_a) * int'(bus0.req1_b)
                                      : int'(bus0.req0_a) * int'(bus0.req0_b);
                m_e.tag  = (m_w == 1) ? int'(bus0.req1_tag) : int'(bus0.req0_tag);
                m_e.due  = cyc + 1 + CALC0;
                sbq.push_back(m_e);
                outstanding++;
            end
            for (int p = 0; p < 2; p++) begin
                m_rv = (p == 1) ? bus0.resp1_valid   : bus0.resp0_valid;
                m_rr = (p == 1) ? bus0.resp1_ready   : bus0.resp0_ready;
                m_rp = (p == 1) ? bus0.resp1_product : bus0.resp0_product;
                m_rt = (p == 1) ? bus0.resp1_tag     : bus0.resp0_tag;
                if (m_rv) begin
                    if (!active[p]) begin
                        if (sbq.size() == 0) begin
                            fail($sformatf("unexpected_resp%0d", p), "resp_valid=1", "no response");
                        end else begin
                            m_e = sbq.pop_front();
                            chk("resp_port", p, m_e.port);
                            chk("resp_latency", cyc, m_e.due);
                            cur[p]    = m_e;
                            active[p] = 1'b1;
                        end
                    end
                    if (active[p]) begin
                        chk("resp_product", int'(m_rp), cur[p].prod);
                        chk("resp_tag", int'(m_rt), cur[p].tag);
                        if (m_rr) begin
                            active[p] = 1'b0;
                            outstanding--;
                        end
                    end
                end else if (active[p]) begin
                    fail($sformatf("resp_dropped%0d", p), "resp_valid=0", "held until handshake");
                end
            end
        end
    end

    task automatic issue(input int p, input int a, input int b, input int tag);
        bit done = 1'b0;
        if (p == 0) begin
            bus0.req0_a = 16'(a); bus0.req0_b = 16'(b); bus0.req0_tag = TW'(tag);
            bus0.req0_valid = 1'b1;
        end else begin
            bus0.req1_a = 16'(a); bus0.req1_b = 16'(b); bus0.req1_tag = TW'(tag);
            bus0.req1_valid = 1'b1;
        end
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk); #1;
            done = (p == 0) ? (bus0.req0_ready === 1'b1) : (bus0.req1_ready === 1'b1);
            @(posedge clk); #1;
        end
        if (p == 0) bus0.req0_valid = 1'b0;
        else        bus0.req1_valid = 1'b0;
        if (!done) fail($sformatf("issue_timeout%0d", p), "never accepted", "accept");
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 300; i++) begin
            if (outstanding == 0 && !bus0.resp0_valid && !bus0.resp1_valid && !busy0) break;
            @(posedge clk); #1;
        end
        if (i == 300) fail("idle_timeout", "still busy", "idle");
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_req0_ready"}, bus0.req0_ready, 0);
        chk({nm, "_req1_ready"}, bus0.req1_ready, 0);
        chk({nm, "_resp0_valid"}, bus0.resp0_valid, 0);
        chk({nm, "_resp1_valid"}, bus0.resp1_valid, 0);
        chk({nm, "_resp0_product"}, int'(bus0.resp0_product), 0);
        chk({nm, "_resp1_product"}, int'(bus0.resp1_product), 0);
        chk({nm, "_resp0_tag"}, int'(bus0.resp0_tag), 0);
        chk({nm, "_resp1_tag"}, int'(bus0.resp1_tag), 0);
        chk({nm, "_busy"}, busy0, 0);
    endtask

    function automatic int rnd16();
        logic signed [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 7))
            0: v = -16'sd32768;
            1: v = 16'sd32767;
            2: v = 16'sd0;
            3: v = -16'sd1;
            default: ;
        endcase
        return int'(v);
    endfunction

    int a1[4] = '{-1500, 7, 32767, -32768};
    int b1[4] = '{21, -9, -2, 3};
    int acc_e[4];
    int k, kr, rise_prev;
    bit acc;

    initial begin
        bus0.req0_valid = 1'b0; bus0.req1_valid = 1'b0;
        bus0.req0_a = '0; bus0.req0_b = '0; bus0.req0_tag = '0;
        bus0.req1_a = '0; bus0.req1_b = '0; bus0.req1_tag = '0;
        bus1.req0_valid = 1'b0; bus1.req1_valid = 1'b0;
        bus1.req0_a = '0; bus1.req0_b = '0; bus1.req0_tag = '0;
        bus1.req1_a = '0; bus1.req1_b = '0; bus1.req1_tag = '0;
        bus1.resp0_ready = 1'b1; bus1.resp1_ready = 1'b1;
        #1;
        chk_zero("reset");
        chk("reset_busy1", busy1, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Arbitration: both valid from reset release; req0, req1, req0.
        fork
            begin issue(0, 2, 3, 1); issue(0, 2, 3, 3); end
            issue(1, -4, 4, 2);
        join
        wait_idle();

        // Single op.
        issue(0, 3, -5, 7);
        wait_idle();

        // Backpressure on resp0 while req1 waits.
        man0 = 1'b0; man1 = 1'b1; rr_mode = 2;
        fork
            issue(0, 1234, -77, 5);
            begin @(posedge clk); #1; issue(1, -300, 41, 9); end
            begin
                for (int i = 0; i < 50 && bus0.resp0_valid !== 1'b1; i++) begin
                    @(posedge clk); #1;
                end
                repeat (5) begin @(posedge clk); #1; end
                man0 = 1'b1;
            end
        join
        wait_idle();
        rr_mode = 0;

        // Reset during CALC: outputs clear asynchronously, no response afterwards.
        issue(0, 111, 222, 3);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk_zero("async_reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        fork
            issue(0, 5, 6, 1);
            issue(1, 7, 8, 2);
        join
        wait_idle();

        // Corner operands.
        issue(0, -32768, -32768, 1);
        issue(1, -32768, 32767, 2);
        issue(0, 32767, 32767, 3);
        issue(1, 0, -1, 4);
        wait_idle();

        // Random traffic with random response backpressure.
        rr_mode = 1;
        fork
            for (int n = 0; n < 60; n++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                issue(0, rnd16(), rnd16(), int'($urandom_range(0, 15)));
            end
            for (int n = 0; n < 60; n++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                issue(1, rnd16(), rnd16(), int'($urandom_range(0, 15)));
            end
        join
        rr_mode = 0;
        wait_idle();

        // CALC_CYCLES=1 instance: latency 1, one op every 3 cycles.
        k = 0; kr = 0; rise_prev = 0;
        bus1.req0_a = 16'(a1[0]); bus1.req0_b = 16'(b1[0]); bus1.req0_tag = '0;
        bus1.req0_valid = 1'b1;
        for (int i = 0; i < 60 && kr < 4; i++) begin
            @(negedge clk); #1;
            acc = bus1.req0_valid && bus1.req0_ready;
            if (acc) acc_e[k] = cyc + 1;
            if (bus1.resp0_valid) begin
                chk("c1_product", int'(bus1.resp0_product), a1[kr] * b1[kr]);
                chk("c1_tag", int'(bus1.resp0_tag), kr);
                chk("c1_latency", cyc - acc_e[kr], 1);
                if (kr > 0) chk("c1_spacing", cyc - rise_prev, 3);
                chk("c1_resp1_valid", bus1.resp1_valid, 0);
                rise_prev = cyc;
                kr++;
            end
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k < 4) begin
                    bus1.req0_a = 16'(a1[k]); bus1.req0_b = 16'(b1[k]); bus1.req0_tag = TW'(k);
                end else begin
                    bus1.req0_valid = 1'b0;
                end
            end
        end
        chk("c1_completed", kr, 4);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end
endmodule
